// File: rtl/seq_sub_pkg.sv
// Shared definitions for the multi-cycle subtractor: state encoding, slice count
// and the parameter-legality helper.
package seq_sub_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DIGIT_DEF = 4;
    localparam int N         = WIDTH_DEF / DIGIT_DEF;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } state_t;

    function automatic int num_slices(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic bit digit_legal(input int width, input int digit);
        return (digit > 0) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

// File: rtl/seq_sub_digit_subtractor.sv
// Combinational DIGIT-bit subtract slice: a + ~b + ~borrow_in on a ripple of
// full adders, so the borrow out is the inverted carry out.
module digit_subtractor #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_bin,
    output logic [DIGIT-1:0] o_diff,
    output logic             o_bout
);
    logic [DIGIT-1:0] w_nb;
    logic [DIGIT:0]   w_carry;

    assign w_nb       = ~i_b;
    assign w_carry[0] = ~i_bin;
    assign o_bout     = ~w_carry[DIGIT];

    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
        full_adder u_fa (
            .i_a    (i_a[gi]),
            .i_b    (w_nb[gi]),
            .i_cin  (w_carry[gi]),
            .o_sum  (o_diff[gi]),
            .o_cout (w_carry[gi+1])
        );
    end
endmodule

// File: rtl/seq_subtractor.sv
// Multi-cycle subtractor: one DIGIT-bit slice per clock, LSB first, with a
// registered borrow between slices and valid/ready on both sides.
import seq_sub_pkg::*;

module seq_subtractor #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow,
    output logic             o_overflow
);
    localparam int NSL = num_slices(WIDTH, DIGIT);
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NSL - 1);

    if (!digit_legal(WIDTH, DIGIT)) begin : g_bad_digit
        $error("seq_subtractor: DIGIT must divide WIDTH");
    end

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_borrow;
    logic               r_a_msb;
    logic               r_b_msb;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_ovf;

    logic [DIGIT-1:0]       w_slice_diff;
    logic                   w_slice_bout;
    logic [WIDTH+DIGIT-1:0] w_res_cat;
    logic [WIDTH-1:0]       w_res_next;
    logic                   w_ovf_next;

    digit_subtractor #(.DIGIT(DIGIT)) u_slice (
        .i_a    (r_a[DIGIT-1:0]),
        .i_b    (r_b[DIGIT-1:0]),
        .i_bin  (r_borrow),
        .o_diff (w_slice_diff),
        .o_bout (w_slice_bout)
    );

    // New slice enters at the top; concatenating first keeps DIGIT==WIDTH legal.
    assign w_res_cat  = {w_slice_diff, r_res};
    assign w_res_next = w_res_cat[WIDTH+DIGIT-1:DIGIT];
    assign w_ovf_next = (r_a_msb != r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);

    assign o_ready    = (r_state == ST_IDLE);
    assign o_valid    = (r_state == ST_DONE);
    assign o_diff     = r_diff;
    assign o_borrow   = r_bout;
    assign o_overflow = r_ovf;

    // Control FSM, slice counter, operand/result shift registers and result outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_a      <= i_a;
                        r_b      <= i_b;
                        r_a_msb  <= i_a[WIDTH-1];
                        r_b_msb  <= i_b[WIDTH-1];
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_res    <= w_res_next;
                    r_a      <= r_a >> DIGIT;
                    r_b      <= r_b >> DIGIT;
                    r_borrow <= w_slice_bout;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_diff  <= w_res_next;
                        r_bout  <= w_slice_bout;
                        r_ovf   <= w_ovf_next;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_subtractor.sv
// Directed bench for seq_subtractor with DIGIT=4, 1 and 32 instances side by side.
module tb_seq_subtractor;

    logic        clk;
    logic        rst;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        v_in  [3];
    logic        r_in  [3];
    logic        o_rdy [3];
    logic        o_vld [3];
    logic [31:0] o_df  [3];
    logic        o_brw [3];
    logic        o_ovf [3];

    int errors = 0;
    int checks = 0;
    int nsl [3] = '{8, 32, 1};

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] diff;
        logic        borrow;
        logic        ovf;
    } vec_t;

    vec_t vecs [9];

    seq_subtractor #(.WIDTH(32), .DIGIT(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_valid(v_in[0]), .o_ready(o_rdy[0]),
        .i_a(i_a), .i_b(i_b), .o_valid(o_vld[0]), .i_ready(r_in[0]),
        .o_diff(o_df[0]), .o_borrow(o_brw[0]), .o_overflow(o_ovf[0]));

    seq_subtractor #(.WIDTH(32), .DIGIT(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(v_in[1]), .o_ready(o_rdy[1]),
        .i_a(i_a), .i_b(i_b), .o_valid(o_vld[1]), .i_ready(r_in[1]),
        .o_diff(o_df[1]), .o_borrow(o_brw[1]), .o_overflow(o_ovf[1]));

    seq_subtractor #(.WIDTH(32), .DIGIT(32)) dut32 (
        .i_clk(clk), .i_rst(rst), .i_valid(v_in[2]), .o_ready(o_rdy[2]),
        .i_a(i_a), .i_b(i_b), .o_valid(o_vld[2]), .i_ready(r_in[2]),
        .o_diff(o_df[2]), .o_borrow(o_brw[2]), .o_overflow(o_ovf[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ed, input logic eb, input logic eo);
        int lat;
        i_a = a;
        i_b = b;
        v_in[k] = 1'b1;
        tick();
        v_in[k] = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (o_vld[k] !== 1'b1 && lat < 200);
        chk($sformatf("latency[%0d]", k), lat, nsl[k]);
        chk($sformatf("diff[%0d] %h-%h", k, a, b), o_df[k], ed);
        chk($sformatf("borrow[%0d] %h-%h", k, a, b), {31'd0, o_brw[k]}, {31'd0, eb});
        chk($sformatf("ovf[%0d] %h-%h", k, a, b), {31'd0, o_ovf[k]}, {31'd0, eo});
        chk($sformatf("ready_in_done[%0d]", k), {31'd0, o_rdy[k]}, 32'd0);
        r_in[k] = 1'b1;
        tick();
        r_in[k] = 1'b0;
        chk($sformatf("valid_drop[%0d]", k), {31'd0, o_vld[k]}, 32'd0);
    endtask

    task automatic b2b(input int k);
        int  t;
        bit  seen1;
        bit  seen2;
        t = 0;
        seen1 = 1'b0;
        seen2 = 1'b0;
        r_in[k] = 1'b1;
        i_a = 32'h1234_5678;
        i_b = 32'h1234_5678;
        v_in[k] = 1'b1;
        tick();
        i_a = 32'hFFFF_FFFF;
        i_b = 32'h0000_0001;
        while (!seen2 && t < 300) begin
            tick();
            t++;
            if (o_vld[k] === 1'b1 && !seen1) begin
                seen1 = 1'b1;
                chk($sformatf("b2b_lat1[%0d]", k), t, nsl[k]);
                chk($sformatf("b2b_diff1[%0d]", k), o_df[k], 32'h0000_0000);
                chk($sformatf("b2b_borrow1[%0d]", k), {31'd0, o_brw[k]}, 32'd0);
            end else if (o_vld[k] === 1'b1 && seen1) begin
                seen2 = 1'b1;
                v_in[k] = 1'b0;
                chk($sformatf("b2b_lat2[%0d]", k), t, 2 * nsl[k] + 2);
                chk($sformatf("b2b_diff2[%0d]", k), o_df[k], 32'hFFFF_FFFE);
                chk($sformatf("b2b_borrow2[%0d]", k), {31'd0, o_brw[k]}, 32'd0);
            end
        end
        if (!seen2) begin
            chk($sformatf("b2b_timeout[%0d]", k), {31'd0, seen2}, 32'd1);
        end
        v_in[k] = 1'b0;
        tick();
        r_in[k] = 1'b0;
        chk($sformatf("b2b_idle[%0d]", k), {31'd0, o_rdy[k]}, 32'd1);
    endtask

    initial begin
        int vcnt;
        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1};
        vecs[4] = '{32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0};
        vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1, 1'b0};
        vecs[7] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h4B4B_4B4B, 1'b0, 1'b1};
        vecs[8] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0};

        rst = 1'b1;
        i_a = 32'd0;
        i_b = 32'd0;
        for (int k = 0; k < 3; k++) begin
            v_in[k] = 1'b0;
            r_in[k] = 1'b0;
        end
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_ready[%0d]", k), {31'd0, o_rdy[k]}, 32'd1);
            chk($sformatf("rst_valid[%0d]", k), {31'd0, o_vld[k]}, 32'd0);
            chk($sformatf("rst_diff[%0d]", k), o_df[k], 32'd0);
            chk($sformatf("rst_flags[%0d]", k), {30'd0, o_brw[k], o_ovf[k]}, 32'd0);
        end

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 9; i++) begin
                run_op(k, vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow, vecs[i].ovf);
            end
        end

        // Backpressure: result held in DONE while new operands are offered
        i_a = 32'h0000_0005;
        i_b = 32'h0000_0003;
        v_in[0] = 1'b1;
        tick();
        v_in[0] = 1'b0;
        vcnt = 0;
        while (o_vld[0] !== 1'b1 && vcnt < 200) begin
            tick();
            vcnt++;
        end
        i_a = 32'h0000_0100;
        i_b = 32'h0000_0001;
        v_in[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_valid", {31'd0, o_vld[0]}, 32'd1);
            chk("bp_ready", {31'd0, o_rdy[0]}, 32'd0);
            chk("bp_diff", o_df[0], 32'h0000_0002);
        end
        r_in[0] = 1'b1;
        tick();
        r_in[0] = 1'b0;
        chk("bp_idle_ready", {31'd0, o_rdy[0]}, 32'd1);
        chk("bp_idle_hold", o_df[0], 32'h0000_0002);
        tick();
        v_in[0] = 1'b0;
        chk("bp_accept", {31'd0, o_rdy[0]}, 32'd0);
        vcnt = 0;
        do begin
            tick();
            vcnt++;
        end while (o_vld[0] !== 1'b1 && vcnt < 200);
        chk("bp_new_lat", vcnt, 8);
        chk("bp_new_diff", o_df[0], 32'h0000_00FF);
        r_in[0] = 1'b1;
        tick();
        r_in[0] = 1'b0;

        // Reset three edges after accept discards the in-flight result
        i_a = 32'h0000_0005;
        i_b = 32'h0000_0003;
        v_in[0] = 1'b1;
        tick();
        v_in[0] = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ready", {31'd0, o_rdy[0]}, 32'd1);
        chk("mid_rst_valid", {31'd0, o_vld[0]}, 32'd0);
        chk("mid_rst_diff", o_df[0], 32'd0);
        vcnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (o_vld[0] !== 1'b0) vcnt++;
        end
        chk("mid_rst_no_valid", vcnt, 0);

        for (int k = 0; k < 3; k++) begin
            b2b(k);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_subtractor.md
# seq_subtractor

Multi-cycle 32-bit subtractor: computes i_a − i_b one DIGIT-bit slice per clock, LSB slice first, rippling a registered borrow between slices. It is the inverse-operation companion to the combinational ripple adder: same operand widths, opposite arithmetic direction. It trades latency for a short critical path and uses a valid/ready handshake on both sides so it can sit in a pipelined datapath.

## Interface
Parameters:
- WIDTH, 32, operand and result width.
- DIGIT, 4, bits processed per cycle. Must divide WIDTH; legal values are 1, 2, 4, 8, 16 and 32.

Ports:
- i_clk  in  1  clock; all state updates on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  operand request.
- o_ready  out  1  block can accept operands.
- i_a  in  WIDTH  minuend, unsigned or two's complement.
- i_b  in  WIDTH  subtrahend.
- o_valid  out  1  result available.
- i_ready  in  1  consumer accepts the result.
- o_diff  out  WIDTH  (i_a − i_b) mod 2^WIDTH.
- o_borrow  out  1  1 when i_a < i_b as unsigned numbers.
- o_overflow  out  1  signed overflow: a[MSB]≠b[MSB] and diff[MSB]≠a[MSB].

## Operation
- N = WIDTH/DIGIT slices. The FSM has three states:
  - IDLE: o_ready=1. When i_valid=1, capture i_a and i_b into shift registers, clear the borrow, set cnt=0, and go to RUN.
  - RUN: each cycle, slice = a[DIGIT-1:0] − b[DIGIT-1:0] − borrow. The slice result shifts into the top of the result register, a and b shift right by DIGIT, borrow takes the slice borrow-out, and cnt increments. When cnt==N−1, load o_diff, o_borrow and o_overflow and go to DONE.
  - DONE: o_valid=1. When i_ready=1, go to IDLE.
- o_overflow is computed from the captured operand MSBs, held in registers, and the final diff MSB.
- o_ready = (state==IDLE). o_valid = (state==DONE). Both are decoded from registered state.
- o_diff, o_borrow and o_overflow update only on the RUN→DONE transition. They hold their value in every other state.
- i_valid is ignored outside IDLE. i_a and i_b are sampled only on the accept edge and may change afterward.
- i_ready is ignored outside DONE.

## Timing
- Reset: state=IDLE, o_ready=1, o_valid=0, o_diff=0, o_borrow=0, o_overflow=0, cnt=0, internal borrow=0.
- Latency: operands accepted at edge T; o_valid rises after edge T+N (T+8 for default parameters).
- Backpressure: while i_ready=0 in DONE, o_valid and all result outputs stay stable indefinitely.
- Throughput: the earliest next accept is edge T+N+2 when i_ready=1 in the first DONE cycle, giving one operation per N+2 cycles.
- Reset mid-operation: i_rst asserted in any state wins over every other event. The next state is IDLE with the reset values above, the in-flight result is discarded, and o_valid is never asserted for it.
- DIGIT=WIDTH: N=1, so RUN lasts one cycle.
- cnt width is clog2(N), minimum 1 bit. There is no wrap-around, because cnt is cleared on every accept.

## Structure
- Shared package seq_sub_pkg holds:
  - the state encoding localparams: S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - the derived constant N;
  - a parameter-legality check (DIGIT divides WIDTH).
- One sub-module, digit_subtractor: combinational DIGIT-bit slice. Inputs are a, b and borrow-in; outputs are diff and borrow-out. Build it as an adder on ~b with carry-in = ~borrow-in, so borrow-out = ~carry-out. Build it from the team's existing full_adder cells.
- Top level holds the FSM, cnt, the operand and result shift registers, and the output registers.

## Test plan
- a=0x0000_0005, b=0x0000_0003 → o_diff=0x0000_0002, o_borrow=0, o_overflow=0; o_valid rises exactly 8 cycles after the accept edge.
- a=0x0000_0000, b=0x0000_0001 → o_diff=0xFFFF_FFFF, o_borrow=1, o_overflow=0. This checks borrow propagation through all 8 slices.
- a=0x8000_0000, b=0x0000_0001 → o_diff=0x7FFF_FFFF, o_borrow=0, o_overflow=1. Also a=0x7FFF_FFFF, b=0xFFFF_FFFF → o_diff=0x8000_0000, o_borrow=1, o_overflow=1.
- Backpressure: hold i_ready=0 for 5 cycles in DONE while driving i_valid=1 with new operands → outputs are stable, o_ready=0, and the new operands are not accepted until IDLE.
- Reset at accept+3 → the next cycle shows o_ready=1, o_valid=0 and o_diff=0, and o_valid stays 0 for the following 10 cycles.
- Back-to-back: a=b=0x1234_5678 with i_ready tied high, then a=0xFFFF_FFFF, b=0x1 → first result 0x0 with borrow 0; second accepted at T+10 with result 0xFFFF_FFFE. Repeat the sequence with DIGIT=1 (32-cycle latency) and DIGIT=32 (1-cycle RUN).
